// File: rtl/decode_pkg.sv
// Shared decode-path types: the instruction word width and its type.
package decode_pkg;

  localparam int INSTR_WIDTH = 32;

  typedef logic [INSTR_WIDTH-1:0] instr_t;

endpackage

// File: rtl/instr_fetch_queue.sv
// Show-ahead instruction FIFO between fetch and the decode buffer.
// Registered status only; flush clears occupancy without touching storage.
module instr_fetch_queue
  import decode_pkg::*;
#(
  parameter int WIDTH = INSTR_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // count is tracked explicitly so full and empty stay distinct when pointers meet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_instr_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready;
  logic [2:0]        count;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] got[$];

  instr_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: occupancy is the queue size, FIFO order is the queue order.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      logic do_push;
      logic do_pop;
      do_push = in_valid && (model_q.size() != DEPTH);
      do_pop  = out_ready && (model_q.size() != 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(model_q.size()));
    chk("m_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    chk("m_in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
    if (reset) chk("m_rst_data", out_data, 32'h0);
    else if (model_q.size() != 0) chk("m_out_data", out_data, model_q[0]);
  end

  initial begin
    logic acc;
    logic [WIDTH-1:0] exp5 [5];
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;

    // Reset held with a word offered: nothing is visible or stored.
    tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_data", out_data, 32'h0);
    tick();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    tick();
    chk("post_rst_count", 32'(count), 32'h0);

    // Single word, one-cycle latency.
    in_valid = 1'b1; in_data = 32'h00000013;
    tick();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data", out_data, 32'h13);
    chk("single_count", 32'(count), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_count", 32'(count), 32'h0);
    chk("single_pop_valid", 32'(out_valid), 32'h0);

    // Fill to full, fifth word held off until space opens.
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      tick();
    end
    in_data = 32'd5;
    chk("full_count", 32'(count), 32'h4);
    chk("full_ready", 32'(in_ready), 32'h0);
    tick();
    chk("full_hold_count", 32'(count), 32'h4);
    out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 12 && got.size() < 5; c++) begin
      if (out_valid) got.push_back(out_data);
      acc = in_valid && in_ready;
      tick();
      if (c == 0) begin
        chk("first_pop_count", 32'(count), 32'h3);
        chk("first_pop_ready", 32'(in_ready), 32'h1);
      end
      if (acc) in_valid = 1'b0;
    end
    exp5 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    chk("fill_n", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("fill_order", got[i], exp5[i]);
    out_ready = 1'b0; in_valid = 1'b0;
    chk("fill_drained", 32'(count), 32'h0);

    // Streaming through the pointer wrap.
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      if (out_valid) got.push_back(out_data);
      tick();
      chk("stream_count", 32'(count), 32'h1);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4 && count != 0; c++) begin
      if (out_valid) got.push_back(out_data);
      tick();
    end
    out_ready = 1'b0;
    chk("stream_n", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("stream_order", got[i], 32'(i));

    // Flush discards queued words and a same-cycle push.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + WIDTH'(i);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hAA; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b1; in_data = 32'hBB;
    tick();
    in_valid = 1'b0;
    chk("post_flush_data", out_data, 32'hBB);
    chk("post_flush_count", 32'(count), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_flush_empty", 32'(count), 32'h0);

    // Asynchronous reset between edges.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h200 + WIDTH'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_arst_count", 32'(count), 32'h2);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_data", out_data, 32'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    tick();
    chk("post_arst_count", 32'(count), 32'h0);
    in_valid = 1'b1; in_data = 32'h3C;
    tick();
    in_valid = 1'b0;
    chk("post_arst_data", out_data, 32'h3C);
    out_ready = 1'b1;
    tick();

    // Random traffic checked by the model.
    for (int c = 0; c < 500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = $urandom;
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
